dcache_axi_master: RTL

Memory-side bridge directly downstream of the L1 data cache. It accepts the cache's simple request interface (D_req/D_addr/D_write/D_in/D_type) and converts it into AXI4 master transactions:
- 4-beat INCR read bursts for line fills;
- single-beat writes for write-through stores.

Progress is returned to the cache as one-cycle D_wait=0 pulses plus read data on D_out. The block sits between the data cache and the system AXI interconnect, inside the CPU wrapper.

---
 rtl/dcache_axi_master_pkg.sv | 37 +++
 rtl/dcache_wstrb_gen.sv | 33 +++
 rtl/dcache_axi_master.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/dcache_axi_master_pkg.sv
// -----------------------------------------------------------------------------
// dcache_axi_master_pkg
// Shared definitions for the data-cache AXI bridge:
//   - AXI4 encodings used by the bridge (burst type, beat size, single-beat len)
//   - cache access type codes shared with the L1 data cache
//   - bridge FSM state type
//   - line_align(): byte address -> 16-byte line base
// -----------------------------------------------------------------------------
package dcache_axi_master_pkg;

    // AXI4 encodings
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [3:0] LEN_SINGLE = 4'd0;

    // Cache access type codes (shared with the cache and the instruction side)
    localparam logic [2:0] CACHE_BYTE    = 3'd0;
    localparam logic [2:0] CACHE_HWORD   = 3'd1;
    localparam logic [2:0] CACHE_WORD    = 3'd2;
    localparam logic [2:0] CACHE_BYTE_U  = 3'd4;
    localparam logic [2:0] CACHE_HWORD_U = 3'd5;

    // Bridge FSM states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW_W = 3'd3,
        ST_B    = 3'd4
    } dcache_state_e;

    // A line is four 32-bit words, so fills always start on a 16-byte boundary.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:4], 4'h0};
    endfunction

endpackage

// File: rtl/dcache_wstrb_gen.sv
// -----------------------------------------------------------------------------
// dcache_wstrb_gen
// Combinational store lane placement for a 32-bit AXI write data bus.
// Ports:
//   d_type  in  3   cache access type code (CACHE_*)
//   addr_lo in  2   byte offset within the word
//   data_in in  32  right-aligned store data
//   wstrb   out 4   byte-lane strobes
//   wdata   out 32  store data shifted onto its byte lanes
// -----------------------------------------------------------------------------
module dcache_wstrb_gen
    import dcache_axi_master_pkg::*;
(
    input  logic [2:0]  d_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data_in,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata
);

    always_comb begin
        // Data is shifted by the full byte offset; the strobes select the
        // lanes that actually matter for the access size.
        wdata = data_in << {addr_lo, 3'b000};
        case (d_type)
            CACHE_BYTE, CACHE_BYTE_U:   wstrb = 4'b0001 << addr_lo;
            CACHE_HWORD, CACHE_HWORD_U: wstrb = 4'b0011 << {addr_lo[1], 1'b0};
            CACHE_WORD:                 wstrb = 4'b1111;
            default:                    wstrb = 4'b0000;
        endcase
    end

endmodule

// File: rtl/dcache_axi_master.sv
// -----------------------------------------------------------------------------
// dcache_axi_master
// Bridge from the L1 data cache request interface to an AXI4 master.
// Reads become READ_BEATS-beat INCR line fills; writes become single-beat
// write-through stores. Completion is signalled back to the cache as one-cycle
// D_wait=0 pulses (one per read beat, one per write response).
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   D_req/D_addr/D_write/D_in/D_type cache request (sampled in IDLE only)
//   D_out, D_wait                    read beat data, progress strobe (active low)
//   AR*/R*                           AXI read address / read data channels
//   AW*/W*/B*                        AXI write address / data / response channels
// -----------------------------------------------------------------------------
module dcache_axi_master
    import dcache_axi_master_pkg::*;
#(
    parameter logic [3:0] ID_VAL     = 4'd1,
    parameter int         READ_BEATS = 4
)
(
    input  logic        clk,
    input  logic        rst,
    // cache side
    input  logic        D_req,
    input  logic [31:0] D_addr,
    input  logic        D_write,
    input  logic [31:0] D_in,
    input  logic [2:0]  D_type,
    output logic [31:0] D_out,
    output logic        D_wait,
    // read address channel
    output logic [3:0]  ARID,
    output logic [31:0] ARADDR,
    output logic [3:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,
    // read data channel
    input  logic [3:0]  RID,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY,
    // write address channel
    output logic [3:0]  AWID,
    output logic [31:0] AWADDR,
    output logic [3:0]  AWLEN,
    output logic [2:0]  AWSIZE,
    output logic [1:0]  AWBURST,
    output logic        AWVALID,
    input  logic        AWREADY,
    // write data channel
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    output logic        WLAST,
    output logic        WVALID,
    input  logic        WREADY,
    // write response channel
    input  logic [3:0]  BID,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY
);

    dcache_state_e state_reg, state_next;
    logic [31:0]   addr_reg, addr_next;
    logic [31:0]   data_reg, data_next;
    logic [2:0]    type_reg, type_next;
    logic          aw_done_reg, aw_done_next;
    logic          w_done_reg, w_done_next;

    logic          in_aw_w;
    logic [3:0]    strb_raw;
    logic [31:0]   wdata_raw;

    // Response IDs and status are deliberately not checked.
    logic          unused_inputs;
    assign unused_inputs = ^{RID, RRESP, BID, BRESP};

    assign in_aw_w = (state_reg == ST_AW_W);

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        data_next    = data_reg;
        type_next    = type_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        case (state_reg)
            ST_IDLE: begin
                if (D_req) begin
                    addr_next    = D_addr;
                    data_next    = D_in;
                    type_next    = D_type;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    state_next   = D_write ? ST_AW_W : ST_AR;
                end
            end
            ST_AR: begin
                if (ARREADY) state_next = ST_R;
            end
            ST_R: begin
                // The slave's RLAST ends the fill; gaps in RVALID just stall.
                if (RVALID && RLAST) state_next = ST_IDLE;
            end
            ST_AW_W: begin
                // The two channels complete independently, possibly together.
                aw_done_next = aw_done_reg | AWREADY;
                w_done_next  = w_done_reg  | WREADY;
                if (aw_done_next && w_done_next) state_next = ST_B;
            end
            ST_B: begin
                if (BVALID) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= 32'h0;
            data_reg    <= 32'h0;
            type_reg    <= 3'h0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            data_reg    <= data_next;
            type_reg    <= type_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
        end
    end

    // ---------------------------------------------------------------- read side
    assign ARID    = ID_VAL;
    assign ARADDR  = line_align(addr_reg);
    assign ARLEN   = 4'(READ_BEATS - 1);
    assign ARSIZE  = SIZE_WORD;
    assign ARBURST = BURST_INCR;
    assign ARVALID = (state_reg == ST_AR);
    assign RREADY  = (state_reg == ST_R);
    assign D_out   = (state_reg == ST_R) ? RDATA : 32'h0;

    // ---------------------------------------------------------------- write side
    assign AWID    = ID_VAL;
    assign AWADDR  = addr_reg;
    assign AWLEN   = LEN_SINGLE;
    assign AWSIZE  = SIZE_WORD;
    assign AWBURST = BURST_INCR;
    assign AWVALID = in_aw_w & ~aw_done_reg;
    assign WVALID  = in_aw_w & ~w_done_reg;
    assign WLAST   = 1'b1;
    assign BREADY  = (state_reg == ST_B);

    dcache_wstrb_gen u_wstrb_gen (
        .d_type  (type_reg),
        .addr_lo (addr_reg[1:0]),
        .data_in (data_reg),
        .wstrb   (strb_raw),
        .wdata   (wdata_raw)
    );

    // Lanes are only driven while a store is in progress so the bus rests at 0.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign WSTRB[gi]        = in_aw_w & strb_raw[gi];
            assign WDATA[8*gi +: 8] = in_aw_w ? wdata_raw[8*gi +: 8] : 8'h00;
        end
    endgenerate

    // One completion pulse per accepted read beat or write response.
    assign D_wait = ~(((state_reg == ST_R) && RVALID) || ((state_reg == ST_B) && BVALID));

endmodule
